// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multi-cycle control FSM and the MIPS datapath.
// master: the control unit (drives enables/selects, sees instruction fields and flags).
// slave: the datapath/memory side.
interface multicycle_control_unit_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal_op;
  logic       bus_error;

  modport master (
    input  OpCode, Funct, zero, mem_ready,
    output mem_req, i_or_d, mem_write, ir_write, pc_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src,
           instr_done, illegal_op, bus_error
  );

  modport slave (
    output OpCode, Funct, zero, mem_ready,
    input  mem_req, i_or_d, mem_write, ir_write, pc_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src,
           instr_done, illegal_op, bus_error
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives every datapath enable and mux select, handles memory handshake with
// timeout, and flags illegal instructions.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned ENABLE_BNE  = 1,
  parameter int unsigned ENABLE_ADDI = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_control_unit_if.master  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  state_t          state, state_n;
  logic [TO_W-1:0] cnt;
  logic            wait_state;
  logic            mem_to;
  logic            funct_ok;

  assign wait_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign mem_to     = (MEM_TIMEOUT != 0) && wait_state && !bus.mem_ready &&
                      (cnt == TO_LAST);
  assign funct_ok   = (bus.Funct == FN_ADD) || (bus.Funct == FN_SUB) ||
                      (bus.Funct == FN_AND) || (bus.Funct == FN_OR)  ||
                      (bus.Funct == FN_SLT);

  // State register and memory wait counter; counter restarts whenever a state
  // is (re)entered, including FETCH re-entering itself after a timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if ((state_n != state) || mem_to)
        cnt <= '0;
      else if (wait_state && !bus.mem_ready)
        cnt <= cnt + TO_W'(1);
    end
  end

  // Next-state logic and output decode; everything held at 0 during reset.
  always_comb begin
    state_n         = state;
    bus.mem_req     = 1'b0;
    bus.i_or_d      = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.alu_control = 3'b000;
    bus.pc_src      = 2'b00;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.bus_error   = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          bus.mem_req     = 1'b1;
          bus.alu_src_b   = 2'b01;
          bus.alu_control = 3'b010;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_n      = DECODE;
          end else if (mem_to) begin
            bus.bus_error = 1'b1;
          end
        end
        DECODE: begin
          bus.alu_src_b   = 2'b11;
          bus.alu_control = 3'b010;
          case (bus.OpCode)
            OP_LW, OP_SW: state_n = MEMADR;
            OP_RTYPE:     state_n = funct_ok ? EXEC : FETCH;
            OP_BEQ:       state_n = BRANCH;
            OP_BNE:       state_n = (ENABLE_BNE != 0) ? BRANCH : FETCH;
            OP_ADDI:      state_n = (ENABLE_ADDI != 0) ? ADDIEX : FETCH;
            OP_J:         state_n = JUMP;
            default:      state_n = FETCH;
          endcase
          if (state_n == FETCH) begin
            bus.illegal_op = 1'b1;
            bus.instr_done = 1'b1;
          end
        end
        MEMADR: begin
          bus.alu_src_a   = 1'b1;
          bus.alu_src_b   = 2'b10;
          bus.alu_control = 3'b010;
          state_n         = (bus.OpCode == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          bus.mem_req = 1'b1;
          bus.i_or_d  = 1'b1;
          if (bus.mem_ready) begin
            state_n = MEMWB;
          end else if (mem_to) begin
            bus.bus_error = 1'b1;
            state_n       = FETCH;
          end
        end
        MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
          state_n        = FETCH;
        end
        MEMWR: begin
          bus.mem_req   = 1'b1;
          bus.i_or_d    = 1'b1;
          bus.mem_write = 1'b1;
          if (bus.mem_ready) begin
            bus.instr_done = 1'b1;
            state_n        = FETCH;
          end else if (mem_to) begin
            bus.bus_error = 1'b1;
            state_n       = FETCH;
          end
        end
        EXEC: begin
          bus.alu_src_a = 1'b1;
          case (bus.Funct)
            FN_SUB:  bus.alu_control = 3'b110;
            FN_AND:  bus.alu_control = 3'b000;
            FN_OR:   bus.alu_control = 3'b001;
            FN_SLT:  bus.alu_control = 3'b111;
            default: bus.alu_control = 3'b010;
          endcase
          state_n = ALUWB;
        end
        ALUWB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 1'b1;
          bus.instr_done = 1'b1;
          state_n        = FETCH;
        end
        BRANCH: begin
          bus.alu_src_a   = 1'b1;
          bus.alu_control = 3'b110;
          bus.pc_src      = 2'b01;
          bus.pc_write    = (bus.OpCode == OP_BNE) ? !bus.zero : bus.zero;
          bus.instr_done  = 1'b1;
          state_n         = FETCH;
        end
        ADDIEX: begin
          bus.alu_src_a   = 1'b1;
          bus.alu_src_b   = 2'b10;
          bus.alu_control = 3'b010;
          state_n         = ADDIWB;
        end
        ADDIWB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
          state_n        = FETCH;
        end
        JUMP: begin
          bus.pc_src     = 2'b10;
          bus.pc_write   = 1'b1;
          bus.instr_done = 1'b1;
          state_n        = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-level model expands each
// instruction into its expected per-cycle control vector; randomized program
// with random memory latencies plus directed cases.
module tb_multicycle_control_unit;

  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_unit_if bus_if ();

  multicycle_control_unit #(
    .MEM_TIMEOUT (TMO),
    .TO_W        (8),
    .ENABLE_BNE  (1),
    .ENABLE_ADDI (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic       mem_req, i_or_d, mem_write, ir_write, pc_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       instr_done, illegal_op, bus_error;
  } ctl_t;

  typedef struct {
    logic       rst;
    logic       ready;
    logic       zero;
    logic [5:0] op;
    logic [5:0] funct;
    ctl_t       exp;
  } step_t;

  step_t q[$];
  int    passed = 0;
  int    total  = 0;
  int    cycle  = 0;

  logic [5:0] cur_op, cur_funct;
  logic       cur_zero;

  function automatic void push(input logic rdy, input ctl_t c, input logic rst = 1'b1);
    step_t s;
    s.rst   = rst;
    s.ready = rdy;
    s.zero  = cur_zero;
    s.op    = cur_op;
    s.funct = cur_funct;
    s.exp   = c;
    q.push_back(s);
  endfunction

  // Memory phase lasting lat not-ready cycles before ready; returns 0 on timeout.
  function automatic bit mem_phase(input int lat, input ctl_t waiting, input ctl_t done);
    ctl_t e;
    for (int k = 0; ; k++) begin
      if (k == lat) begin
        push(1'b1, done);
        return 1'b1;
      end
      if (k == TMO - 1) begin
        e = waiting;
        e.bus_error = 1'b1;
        push(1'b0, e);
        return 1'b0;
      end
      push(1'b0, waiting);
    end
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  // kind: 0 lw, 1 sw, 2 R-legal, 3 R-bad-funct, 4 beq, 5 bne, 6 addi, 7 j, 8 bad opcode
  function automatic void plan(input int kind, input logic [5:0] f, input logic z,
                               input int lat_f, input int lat_m);
    ctl_t c, d;
    logic [5:0] ops[9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000,
                           6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b000000};
    cur_op    = ops[kind];
    cur_funct = f;
    cur_zero  = z;
    if (kind == 8) cur_op = f;
    c = '0; c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.alu_control = 3'b010;
    d = c;  d.ir_write = 1'b1; d.pc_write = 1'b1;
    if (!mem_phase(lat_f, c, d)) return;
    c = '0; c.alu_src_b = 2'b11; c.alu_control = 3'b010;
    if (kind == 3 || kind == 8) begin
      c.illegal_op = 1'b1; c.instr_done = 1'b1;
      push(1'b0, c);
      return;
    end
    push(1'b0, c);
    c = '0;
    case (kind)
      0, 1: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = 3'b010;
        push(1'b0, c);
        c = '0; c.mem_req = 1'b1; c.i_or_d = 1'b1; c.mem_write = (kind == 1);
        d = c;  d.instr_done = (kind == 1);
        if (!mem_phase(lat_m, c, d)) return;
        if (kind == 0) begin
          c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
          push(1'b0, c);
        end
      end
      2: begin
        c.alu_src_a = 1'b1; c.alu_control = alu_of(f);
        push(1'b0, c);
        c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1;
        push(1'b0, c);
      end
      4, 5: begin
        c.alu_src_a = 1'b1; c.alu_control = 3'b110; c.pc_src = 2'b01;
        c.pc_write = (kind == 4) ? z : !z;
        c.instr_done = 1'b1;
        push(1'b0, c);
      end
      6: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = 3'b010;
        push(1'b0, c);
        c = '0; c.reg_write = 1'b1; c.instr_done = 1'b1;
        push(1'b0, c);
      end
      default: begin
        c.pc_src = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1;
        push(1'b0, c);
      end
    endcase
  endfunction

  function automatic ctl_t observe();
    ctl_t o;
    o.mem_req     = bus_if.mem_req;     o.i_or_d      = bus_if.i_or_d;
    o.mem_write   = bus_if.mem_write;   o.ir_write    = bus_if.ir_write;
    o.pc_write    = bus_if.pc_write;    o.reg_write   = bus_if.reg_write;
    o.reg_dst     = bus_if.reg_dst;     o.mem_to_reg  = bus_if.mem_to_reg;
    o.alu_src_a   = bus_if.alu_src_a;   o.alu_src_b   = bus_if.alu_src_b;
    o.alu_control = bus_if.alu_control; o.pc_src      = bus_if.pc_src;
    o.instr_done  = bus_if.instr_done;  o.illegal_op  = bus_if.illegal_op;
    o.bus_error   = bus_if.bus_error;
    return o;
  endfunction

  task automatic run_queue();
    step_t s;
    ctl_t  o;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(posedge clk);
      #1;
      rst_n            = s.rst;
      bus_if.mem_ready = s.ready;
      bus_if.zero      = s.zero;
      bus_if.OpCode    = s.op;
      bus_if.Funct     = s.funct;
      @(negedge clk);
      o = observe();
      cycle++;
      total++;
      assert (o === s.exp) passed++;
      else $error("FAIL ctl cycle %0d op=%b funct=%b rst_n=%b: got %h expected %h",
                  cycle, s.op, s.funct, s.rst, o, s.exp);
    end
  endtask

  initial begin
    int kind, lat_f, lat_m, n0;
    logic [5:0] f;
    logic [5:0] good_f[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] bad_f[4]  = '{6'b000000, 6'b100001, 6'b100110, 6'b101011};
    logic [5:0] bad_op[4] = '{6'b111111, 6'b001100, 6'b000011, 6'b100000};
    int lat_pick[4] = '{5, 15, 16, 20};

    rst_n = 1'b0;
    bus_if.mem_ready = 1'b1; bus_if.zero = 1'b1;
    bus_if.OpCode = 6'b100011; bus_if.Funct = 6'b100000;
    cur_op = 6'b100011; cur_funct = 6'b100000; cur_zero = 1'b1;

    // reset: all outputs low even with ready asserted
    repeat (3) push(1'b1, '0, 1'b0);
    // directed: lw, sub, beq z=1/z=0, bne z=0, sw lat 5, fetch timeout, illegal op
    plan(0, 6'b000000, 1'b0, 0, 0);
    plan(2, 6'b100010, 1'b0, 0, 0);
    plan(4, 6'b000000, 1'b1, 0, 0);
    plan(4, 6'b000000, 1'b0, 0, 0);
    plan(5, 6'b000000, 1'b0, 0, 0);
    plan(1, 6'b000000, 1'b0, 0, 5);
    plan(7, 6'b000000, 1'b0, 20, 0);
    plan(7, 6'b000000, 1'b0, 15, 0);
    plan(8, 6'b111111, 1'b0, 0, 0);
    plan(0, 6'b000000, 1'b0, 1, 16);
    plan(1, 6'b000000, 1'b0, 0, 15);
    // lw abandoned by reset in MEMRD
    n0 = q.size();
    plan(0, 6'b000000, 1'b0, 0, 20);
    while (q.size() > n0 + 6) void'(q.pop_back());
    repeat (2) push(1'b1, '0, 1'b0);
    run_queue();

    // randomized program
    for (int i = 0; i < 250; i++) begin
      kind  = $urandom_range(0, 8);
      lat_f = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : lat_pick[$urandom_range(0, 3)];
      lat_m = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : lat_pick[$urandom_range(0, 3)];
      case (kind)
        2:       f = good_f[$urandom_range(0, 4)];
        3:       f = bad_f[$urandom_range(0, 3)];
        8:       f = bad_op[$urandom_range(0, 3)];
        default: f = 6'($urandom);
      endcase
      plan(kind, f, 1'($urandom), lat_f, lat_m);
      run_queue();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
